// File: rtl/apb_master_bridge.sv
// APB requester: turns a valid/ready request into APB SETUP/ACCESS toward two slaves
// and returns a one-cycle response pulse with read data or an error flag.
module apb_master_bridge #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic             PCLK,
   input  logic             PRESET,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             rsp_valid,
   output logic [WIDTH-1:0] rsp_rdata,
   output logic             rsp_err,
   output logic             PSEL1,
   output logic             PSEL2,
   output logic             PENABLE,
   output logic             PWRITE,
   output logic [WIDTH-1:0] paddr,
   output logic [WIDTH-1:0] pwdata,
   input  logic             PREADY1,
   input  logic             PREADY2,
   input  logic [WIDTH-1:0] prdata1,
   input  logic [WIDTH-1:0] prdata2
);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_t;

   localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             sel_q, sel_d;  // 0 = slave 1, 1 = slave 2
   logic             pwrite_q, pwrite_d;
   logic [WIDTH-1:0] paddr_q, paddr_d;
   logic [WIDTH-1:0] pwdata_q, pwdata_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             err_q, err_d;
   logic             sel_ready;
   logic [WIDTH-1:0] sel_rdata;

   assign sel_ready = sel_q ? PREADY2 : PREADY1;
   assign sel_rdata = sel_q ? prdata2 : prdata1;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sel_d     = sel_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      PSEL1     = 1'b0;
      PSEL2     = 1'b0;
      PENABLE   = 1'b0;
      unique case (state_q)
         StIdle: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_addr[WIDTH-1:7] != '0) begin
                  // Out-of-range address: answer with an error, no bus activity
                  state_d = StResp;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else begin
                  state_d  = StSetup;
                  sel_d    = req_addr[6];
                  pwrite_d = req_write;
                  paddr_d  = {{(WIDTH-6){1'b0}}, req_addr[5:0]};
                  pwdata_d = req_wdata;
               end
            end
         end
         StSetup: begin
            PSEL1   = ~sel_q;
            PSEL2   = sel_q;
            cnt_d   = '0;
            state_d = StAccess;
         end
         StAccess: begin
            PSEL1   = ~sel_q;
            PSEL2   = sel_q;
            PENABLE = 1'b1;
            if (sel_ready) begin
               state_d = StResp;
               err_d   = 1'b0;
               rdata_d = pwrite_q ? '0 : sel_rdata;
            end else if (cnt_q == CntLast) begin
               state_d = StResp;
               err_d   = 1'b1;
               rdata_d = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StResp: begin
            rsp_valid = 1'b1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         sel_q    <= 1'b0;
         pwrite_q <= 1'b0;
         paddr_q  <= '0;
         pwdata_q <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         pwrite_q <= pwrite_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   assign PWRITE    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with two behavioural 64-word APB memory slaves.
module tb_apb_master_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        PSEL1, PSEL2, PENABLE, PWRITE;
   logic [31:0] paddr, pwdata;
   logic        PREADY1, PREADY2;
   logic [31:0] prdata1, prdata2;
   logic        stall1, force2;

   logic [31:0] mem1 [64] = '{default: 32'h0};
   logic [31:0] mem2 [64] = '{default: 32'h0};

   int errors = 0;
   int checks = 0;

   int          lat, n_setup, n_access;
   logic        saw1, saw2, got_err, got_bus_rsp, pulse2;
   logic [31:0] got_rdata, setup_paddr;

   always #5 clk = ~clk;

   apb_master_bridge #(.WIDTH(32), .TIMEOUT(15)) dut (
      .PCLK(clk), .PRESET(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .paddr(paddr), .pwdata(pwdata),
      .PREADY1(PREADY1), .PREADY2(PREADY2), .prdata1(prdata1), .prdata2(prdata2)
   );

   // Slaves answer one cycle after seeing PSEL&PENABLE; stall1/force2 bend that behaviour
   always @(posedge clk) begin
      if (rst) begin
         PREADY1 <= 1'b0;
         PREADY2 <= 1'b0;
      end else begin
         PREADY1 <= PSEL1 & PENABLE & ~stall1;
         PREADY2 <= force2 | (PSEL2 & PENABLE);
         if (PSEL1 && PENABLE && PREADY1 && PWRITE) mem1[paddr[5:0]] <= pwdata;
         if (PSEL2 && PENABLE && PREADY2 && PWRITE) mem2[paddr[5:0]] <= pwdata;
      end
   end

   assign prdata1 = mem1[paddr[5:0]];
   assign prdata2 = mem2[paddr[5:0]];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One transfer; lat counts cycles after the accept edge until rsp_valid
   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("accept_seen", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1; n_setup = 0; n_access = 0; saw1 = 1'b0; saw2 = 1'b0; setup_paddr = 32'hx;
      while (lat <= 40) begin
         if (PSEL1) saw1 = 1'b1;
         if (PSEL2) saw2 = 1'b1;
         if ((PSEL1 || PSEL2) && !PENABLE) begin
            n_setup++;
            setup_paddr = paddr;
         end
         if ((PSEL1 || PSEL2) && PENABLE) n_access++;
         if (rsp_valid) break;
         @(negedge clk);
         lat++;
      end
      got_err     = rsp_err;
      got_rdata   = rsp_rdata;
      got_bus_rsp = PSEL1 | PSEL2 | PENABLE;
      @(negedge clk);
      pulse2 = rsp_valid;
   endtask

   initial begin
      int acc [8];
      int idx, cyc, bad, nrsp;
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      stall1 = 1'b0; force2 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_psel", 32'({PSEL1, PSEL2, PENABLE, PWRITE}), 32'd0);
      chk("rst_paddr", paddr, 32'd0);
      chk("rst_pwdata", pwdata, 32'd0);

      // Slave 1 write then read
      xfer(1'b1, 32'h05, 32'hDEADBEEF);
      chk("w05_lat", lat, 32'd4);
      chk("w05_setup", n_setup, 32'd1);
      chk("w05_access", n_access, 32'd2);
      chk("w05_psel1", 32'(saw1), 32'd1);
      chk("w05_psel2", 32'(saw2), 32'd0);
      chk("w05_err", 32'(got_err), 32'd0);
      chk("w05_pulse", 32'(pulse2), 32'd0);
      chk("w05_bus_rsp", 32'(got_bus_rsp), 32'd0);
      xfer(1'b0, 32'h05, 32'h0);
      chk("r05_rdata", got_rdata, 32'hDEADBEEF);
      chk("r05_err", 32'(got_err), 32'd0);

      // Slave 2 at same word index
      xfer(1'b1, 32'h45, 32'h12345678);
      chk("w45_psel2", 32'(saw2), 32'd1);
      chk("w45_psel1", 32'(saw1), 32'd0);
      chk("w45_paddr", setup_paddr, 32'h05);
      chk("w45_rdata_zero", got_rdata, 32'd0);
      xfer(1'b0, 32'h05, 32'h0);
      chk("r05b_paddr", setup_paddr, 32'h05);
      chk("r05b_rdata", got_rdata, 32'hDEADBEEF);
      xfer(1'b0, 32'h45, 32'h0);
      chk("r45_rdata", got_rdata, 32'h12345678);

      // Back-to-back writes with req_valid held high
      @(negedge clk);
      idx = 0; cyc = 0; bad = 0; nrsp = 0;
      req_valid = 1'b1; req_write = 1'b1;
      while (idx < 8 && cyc < 100) begin
         req_addr = 32'h10 + 32'(idx);
         req_wdata = 32'h1000 + 32'(idx);
         if (req_ready) begin
            acc[idx] = cyc;
            idx++;
         end
         if (rsp_valid) nrsp++;
         if (rsp_valid && (PSEL1 || PSEL2 || PENABLE)) bad++;
         @(negedge clk);
         cyc++;
      end
      req_valid = 1'b0;
      repeat (6) begin
         if (rsp_valid) nrsp++;
         if (rsp_valid && (PSEL1 || PSEL2 || PENABLE)) bad++;
         @(negedge clk);
      end
      chk("b2b_accepts", idx, 32'd8);
      for (int i = 1; i < 8; i++) chk("b2b_interval", acc[i] - acc[i-1], 32'd5);
      chk("b2b_rsp_count", nrsp, 32'd8);
      chk("b2b_bus_in_rsp", bad, 32'd0);
      xfer(1'b0, 32'h13, 32'h0);
      chk("b2b_r13", got_rdata, 32'h1003);
      xfer(1'b0, 32'h17, 32'h0);
      chk("b2b_r17", got_rdata, 32'h1007);

      // Decode error
      xfer(1'b0, 32'h80, 32'h0);
      chk("dec_lat", lat, 32'd1);
      chk("dec_err", 32'(got_err), 32'd1);
      chk("dec_rdata", got_rdata, 32'd0);
      chk("dec_psel", 32'({saw1, saw2}), 32'd0);
      chk("dec_pulse", 32'(pulse2), 32'd0);

      // Timeout on slave 1 while slave 2's PREADY is stuck high
      stall1 = 1'b1; force2 = 1'b1;
      xfer(1'b0, 32'h05, 32'h0);
      stall1 = 1'b0; force2 = 1'b0;
      chk("to_lat", lat, 32'd17);
      chk("to_access", n_access, 32'd15);
      chk("to_err", 32'(got_err), 32'd1);
      chk("to_rdata", got_rdata, 32'd0);
      chk("to_bus_rsp", 32'(got_bus_rsp), 32'd0);
      xfer(1'b0, 32'h05, 32'h0);
      chk("after_to_rdata", got_rdata, 32'hDEADBEEF);

      // Reset in the middle of ACCESS
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h47; req_wdata = 32'hA5A5A5A5;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("mid_in_access", 32'({PSEL2, PENABLE}), 32'd3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_req_ready", 32'(req_ready), 32'd1);
      chk("mid_ctrl", 32'({rsp_valid, rsp_err, PSEL1, PSEL2, PENABLE, PWRITE}), 32'd0);
      chk("mid_paddr", paddr, 32'd0);
      chk("mid_pwdata", pwdata, 32'd0);
      nrsp = 0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid) nrsp++;
      end
      chk("mid_no_rsp", nrsp, 32'd0);
      xfer(1'b0, 32'h47, 32'h0);
      chk("mid_after_lat", lat, 32'd4);
      chk("mid_after_rdata", got_rdata, 32'd0);
      xfer(1'b0, 32'h45, 32'h0);
      chk("mid_after_r45", got_rdata, 32'h12345678);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
